stairs_animator: RTL
====================

Name: stairs_animator

Overview:
- Parametrised successor to the single-rectangle stair drawer.
- Animates one solid rectangle of configurable size on the 160x120 VGA adapter. The loop is: draw, hold for a programmable number of frames, erase to background, move vertically by a configurable step in a selectable direction, repeat.
- Adds vertical wrap-around, horizontal clipping, a stop request and status outputs.
- Sits between game control logic and the VGA adapter's x/y/colour/plot inputs.

Parameters:
- W, 40, rectangle width in pixels (1..160)
- H, 10, rectangle height in pixels (1..120)
- STEP, 1, pixels moved per MOVE (1..H)
- TICKS_PER_FRAME, 833333, clock cycles per frame tick
- FRAMES_PER_MOVE, 15, frame ticks spent in WAIT
- SCREEN_W, 160, screen width
- SCREEN_H, 120, screen height
- BG_COLOUR, 3'b000, erase colour

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- go  in  1  start request; honoured only in IDLE
- stop  in  1  stop request (level)
- dir  in  1  0 = move up, 1 = move down; sampled in MOVE
- in_x  in  8  left x of rectangle; latched on accepted go
- in_y  in  7  top y of rectangle; latched on accepted go
- colour  in  3  draw colour; latched on accepted go
- out_x  out  8  pixel x to VGA
- out_y  out  7  pixel y to VGA
- out_colour  out  3  pixel colour to VGA
- plot  out  1  pixel write strobe
- busy  out  1  high in every state except IDLE
- cur_y  out  7  current top y
- wrapped  out  1  one-cycle pulse when a MOVE wraps

Behaviour:
- Single clock domain. Reset is synchronous and active-low on reset_n, sampled at the rising clock edge.
- Reset state:
  - state = IDLE
  - out_x = 0, out_y = 0, out_colour = 0
  - plot = 0, busy = 0, wrapped = 0
  - cur_y = 0
  - all counters = 0
- A reset asserted mid-scan aborts the operation immediately. Pixels already plotted are not erased.
- States: IDLE, DRAW, WAIT, ERASE, MOVE.
- IDLE:
  - When go = 1, latch in_x, in_y and colour, and set cur_y = in_y.
  - Next state is DRAW.
  - go in any other state is ignored.
- DRAW:
  - Scans a pixel counter, x-fastest: (qx, qy) from (0, 0) to (W-1, H-1), one pixel per cycle.
  - Takes exactly W*H cycles, then goes to WAIT.
- Outputs during scans:
  - Outputs are registered, one cycle after the counter value.
  - out_x = x0 + qx.
  - out_y = (cur_y + qy) mod SCREEN_H, so the rectangle wraps vertically.
  - plot = 1 only when x0 + qx < SCREEN_W, computed in 9 bits. Off-screen pixels are clipped with plot = 0 but still consume the cycle.
  - out_colour = latched colour.
- WAIT:
  - The tick counter is cleared on entry. Each TICKS_PER_FRAME cycles produce one frame tick.
  - After FRAMES_PER_MOVE ticks, go to ERASE. WAIT therefore lasts exactly TICKS_PER_FRAME*FRAMES_PER_MOVE cycles.
  - If stop = 1 in any WAIT cycle, go to ERASE next cycle.
- ERASE: identical scan to DRAW with out_colour = BG_COLOUR.
- After ERASE:
  - If stop was seen (a sticky flag set by stop = 1 in any non-IDLE state), go to IDLE and clear the flag.
  - Otherwise go to MOVE.
- MOVE (1 cycle):
  - Up, dir = 0: if cur_y >= STEP then cur_y -= STEP, else cur_y = cur_y + SCREEN_H - STEP and wrapped = 1.
  - Down, dir = 1: if cur_y + STEP < SCREEN_H then cur_y += STEP, else cur_y = cur_y + STEP - SCREEN_H and wrapped = 1.
  - Next state is DRAW.
- plot is 0 in IDLE, WAIT and MOVE.
- Steady-state period = 2*W*H + TICKS_PER_FRAME*FRAMES_PER_MOVE + 1 cycles.
- Simultaneous go and stop in IDLE: go wins, and the sticky stop flag is set. One draw/erase pass occurs, then the block returns to IDLE.
- Counter widths are sized with $clog2 of the respective parameter maxima. All coordinate arithmetic is done one bit wider, then reduced.

Decomposition:
- Package stairs_pkg holds:
  - state enum (IDLE, DRAW, WAIT, ERASE, MOVE)
  - SCREEN_W, SCREEN_H defaults
  - colour constants (WHITE = 3'b111, BLACK = 3'b000)
- One sub-module, rect_scanner (params W, H):
  - inputs: clock, reset_n, start, en
  - outputs: qx, qy, last (high on pixel (W-1, H-1))
  - instantiated once and shared by DRAW and ERASE
- FSM, frame timer and position/wrap logic stay in the top module.

Test Plan:
All tests use W=4, H=2, STEP=3, TICKS_PER_FRAME=3, FRAMES_PER_MOVE=2, SCREEN_H=120.
- Basic draw: go with in_x=10, in_y=50, colour=3'b100 -> 8 plot cycles at x=10..13, y=50,51, colour 100; then 6 idle cycles; then 8 erase plots with colour 000; then cur_y=47.
- Period: free-run with dir=0 -> successive DRAW starts exactly 23 cycles apart; cur_y sequence 50, 47, 44.
- Wrap up: in_y=1, dir=0 -> after the first MOVE, cur_y=118 and wrapped pulses once. In the next DRAW, out_y = 118, 119 (rows 0 and 1 also checked for an in_y=119 start: rows 119, 0).
- Wrap down: in_y=118, dir=1 -> cur_y=1, wrapped=1 for exactly one cycle.
- Clipping: in_x=158 -> plot high only for x=158,159; clipped cycles have plot=0; the scan still lasts 8 cycles.
- Stop: stop pulsed during DRAW -> that DRAW completes, ERASE follows with no WAIT delay beyond entry, then IDLE with busy=0 and cur_y unchanged. Reset asserted mid-ERASE -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/stairs_pkg.sv
// Shared types and constants for the stairs rectangle animator.
// Imported by the animator top and its scan-counter helper.
package stairs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        WAIT,
        ERASE,
        MOVE
    } state_t;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    localparam logic [2:0] WHITE = 3'b111;
    localparam logic [2:0] BLACK = 3'b000;

endpackage

// File: rtl/rect_scanner.sv
// x-fastest pixel counter over a W x H rectangle.
// Shared by the draw and erase passes of the animator.
module rect_scanner #(
    parameter int W = 40,
    parameter int H = 10,
    localparam int QXW = (W > 1) ? $clog2(W) : 1,
    localparam int QYW = (H > 1) ? $clog2(H) : 1
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           start,
    input  logic           en,
    output logic [QXW-1:0] qx,
    output logic [QYW-1:0] qy,
    output logic           last
);

    logic x_end;
    logic y_end;

    assign x_end = (qx == QXW'(W - 1));
    assign y_end = (qy == QYW'(H - 1));
    assign last  = x_end && y_end;

    // Wraps to (0,0) after the last pixel so back-to-back passes line up.
    always_ff @(posedge clock) begin
        if (!reset_n || start) begin
            qx <= '0;
            qy <= '0;
        end else if (en) begin
            if (x_end) begin
                qx <= '0;
                qy <= y_end ? '0 : qy + QYW'(1);
            end else begin
                qx <= qx + QXW'(1);
            end
        end
    end

endmodule

// File: rtl/stairs_animator.sv
// Draw / hold / erase / step loop for one solid rectangle on a
// 160x120 VGA adapter, with vertical wrap and horizontal clipping.
module stairs_animator
    import stairs_pkg::*;
#(
    parameter int         W               = 40,
    parameter int         H               = 10,
    parameter int         STEP            = 1,
    parameter int         TICKS_PER_FRAME = 833333,
    parameter int         FRAMES_PER_MOVE = 15,
    parameter int         SCREEN_W        = SCREEN_W_DEF,
    parameter int         SCREEN_H        = SCREEN_H_DEF,
    parameter logic [2:0] BG_COLOUR       = BLACK
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       go,
    input  logic       stop,
    input  logic       dir,
    input  logic [7:0] in_x,
    input  logic [6:0] in_y,
    input  logic [2:0] colour,
    output logic [7:0] out_x,
    output logic [6:0] out_y,
    output logic [2:0] out_colour,
    output logic       plot,
    output logic       busy,
    output logic [6:0] cur_y,
    output logic       wrapped
);

    localparam int QXW = (W > 1) ? $clog2(W) : 1;
    localparam int QYW = (H > 1) ? $clog2(H) : 1;
    localparam int TW  =
        (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam int FW  =
        (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;

    state_t state;
    state_t state_n;

    logic           scan_start;
    logic           scan_en;
    logic           scan_last;
    logic [QXW-1:0] qx;
    logic [QYW-1:0] qy;

    logic [TW-1:0] tick_cnt;
    logic [FW-1:0] frame_cnt;
    logic          tick;
    logic          frame_done;

    logic [7:0] x0;
    logic [2:0] col;
    logic       stop_seen;
    logic       stop_any;
    logic       scanning;

    logic [8:0] pix_x;
    logic [7:0] pix_y;
    logic [7:0] cy_ext;
    logic [7:0] dn_sum;
    logic [6:0] y_next;
    logic       y_wrap;

    rect_scanner #(
        .W (W),
        .H (H)
    ) u_scan (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (scan_start),
        .en      (scan_en),
        .qx      (qx),
        .qy      (qy),
        .last    (scan_last)
    );

    assign tick       = (tick_cnt == TW'(TICKS_PER_FRAME - 1));
    assign frame_done = tick &&
        (frame_cnt == FW'(FRAMES_PER_MOVE - 1));
    assign stop_any   = stop || stop_seen;
    assign busy       = (state != IDLE);
    assign scanning   = (state == DRAW) || (state == ERASE);

    // Coordinates are formed one bit wide, then reduced.
    assign pix_x  = {1'b0, x0} + 9'(qx);
    assign pix_y  = {1'b0, cur_y} + 8'(qy);
    assign cy_ext = {1'b0, cur_y};
    assign dn_sum = cy_ext + 8'(STEP);

    always_comb begin
        y_wrap = 1'b0;
        y_next = cur_y;
        if (dir) begin
            y_wrap = (dn_sum >= 8'(SCREEN_H));
            y_next = 7'(y_wrap ? dn_sum - 8'(SCREEN_H) : dn_sum);
        end else begin
            y_wrap = (cy_ext < 8'(STEP));
            y_next = 7'(y_wrap ? cy_ext + 8'(SCREEN_H - STEP)
                               : cy_ext - 8'(STEP));
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        scan_start = 1'b0;
        scan_en    = 1'b0;
        unique case (state)
            IDLE: begin
                scan_start = 1'b1;
                if (go) state_n = DRAW;
            end
            DRAW: begin
                scan_en = 1'b1;
                if (scan_last) state_n = WAIT;
            end
            WAIT: begin
                scan_start = 1'b1;
                if (stop_any || frame_done) state_n = ERASE;
            end
            ERASE: begin
                scan_en = 1'b1;
                if (scan_last) state_n = stop_any ? IDLE : MOVE;
            end
            MOVE: begin
                scan_start = 1'b1;
                state_n    = DRAW;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_x      <= '0;
            out_y      <= '0;
            out_colour <= '0;
            plot       <= 1'b0;
            wrapped    <= 1'b0;
            cur_y      <= '0;
            x0         <= '0;
            col        <= '0;
            stop_seen  <= 1'b0;
            tick_cnt   <= '0;
            frame_cnt  <= '0;
        end else begin
            plot    <= 1'b0;
            wrapped <= 1'b0;

            if (state == IDLE) begin
                if (go) begin
                    x0        <= in_x;
                    col       <= colour;
                    cur_y     <= in_y;
                    stop_seen <= stop;
                end
            end else if (state == ERASE && scan_last && stop_any) begin
                stop_seen <= 1'b0;
            end else if (stop) begin
                stop_seen <= 1'b1;
            end

            if (scanning) begin
                out_x      <= pix_x[7:0];
                out_y      <= 7'(pix_y >= 8'(SCREEN_H)
                                 ? pix_y - 8'(SCREEN_H) : pix_y);
                out_colour <= (state == ERASE) ? BG_COLOUR : col;
                plot       <= (pix_x < 9'(SCREEN_W));
            end

            if (state == MOVE) begin
                cur_y   <= y_next;
                wrapped <= y_wrap;
            end

            if (state == WAIT) begin
                if (tick) begin
                    tick_cnt  <= '0;
                    frame_cnt <= frame_done ? '0 : frame_cnt + FW'(1);
                end else begin
                    tick_cnt <= tick_cnt + TW'(1);
                end
            end else begin
                tick_cnt  <= '0;
                frame_cnt <= '0;
            end
        end
    end

endmodule
